// File: rtl/mac_feeder_if.sv
// Handshake bundle between the feeder (initiator) and the MAC (responder).
interface mac_feeder_if;
    logic [3:0]  mac_a;
    logic [3:0]  mac_b;
    logic        mac_go;
    logic        mac_done;
    logic [11:0] mac_out;

    modport master (
        output mac_a,
        output mac_b,
        output mac_go,
        input  mac_done,
        input  mac_out
    );

    modport slave (
        input  mac_a,
        input  mac_b,
        input  mac_go,
        output mac_done,
        output mac_out
    );
endinterface

// File: rtl/mac_feeder.sv
// Queues host operand pairs and issues them one at a time to the MAC over a
// go/done handshake, capturing each result and aborting on a stalled MAC.
module mac_feeder #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [3:0]         wr_a,
    input  logic [3:0]         wr_b,
    output logic               full,
    output logic               empty,
    input  logic               start,
    output logic               busy,
    mac_feeder_if.master       mac,
    output logic [11:0]        result,
    output logic               result_valid,
    output logic [7:0]         jobs_done,
    output logic               timeout_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GO,
        WAIT,
        CAPTURE
    } state_t;

    state_t          state_reg, state_next;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic [3:0]      mac_a_reg, mac_b_reg;
    logic [11:0]     result_reg;
    logic [7:0]      jobs_reg;
    logic            err_reg;
    logic [TW-1:0]   tmo_reg;

    logic            push, pop;
    logic            launch, tmo_hit;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    // A write against a full queue is dropped even if a pop frees a slot this cycle.
    assign push    = wr_en && !full;
    assign pop     = (state_reg == LOAD);
    assign launch  = (state_reg == IDLE) && start && !empty;
    assign tmo_hit = (tmo_reg == TW'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = LOAD;
            LOAD:    state_next = GO;
            GO:      state_next = WAIT;
            WAIT: begin
                if (mac.mac_done)  state_next = CAPTURE;
                else if (tmo_hit)  state_next = IDLE;
            end
            CAPTURE: state_next = empty ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {wr_a, wr_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            mac_a_reg  <= '0;
            mac_b_reg  <= '0;
            result_reg <= '0;
            jobs_reg   <= '0;
            err_reg    <= 1'b0;
            tmo_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;

            if (pop) begin
                mac_a_reg <= mem[rd_ptr_reg][7:4];
                mac_b_reg <= mem[rd_ptr_reg][3:0];
            end

            if (launch) begin
                jobs_reg <= '0;
                err_reg  <= 1'b0;
            end

            if (state_reg == GO) tmo_reg <= '0;

            // Result is latched on the done edge so it is already valid
            // during the CAPTURE cycle that raises result_valid.
            if (state_reg == WAIT) begin
                if (mac.mac_done) begin
                    result_reg <= mac.mac_out;
                    jobs_reg   <= jobs_reg + 1'b1;
                end else if (tmo_hit) begin
                    err_reg <= 1'b1;
                end else begin
                    tmo_reg <= tmo_reg + 1'b1;
                end
            end
        end
    end

    assign busy         = (state_reg != IDLE);
    assign mac.mac_go   = (state_reg == GO);
    assign mac.mac_a    = mac_a_reg;
    assign mac.mac_b    = mac_b_reg;
    assign result       = result_reg;
    assign result_valid = (state_reg == CAPTURE);
    assign jobs_done    = jobs_reg;
    assign timeout_err  = err_reg;

endmodule
